// File: rtl/numeric_entry_pkg.sv
// numeric_entry_pkg: PS/2 set-2 key codes, digit decoding and BCD helpers shared by numeric_entry
package numeric_entry_pkg;

  typedef enum logic {IDLE, ENTRY} state_e;

  localparam logic [7:0] KEY_BREAK     = 8'hF0;
  localparam logic [7:0] KEY_EXT       = 8'hE0;
  localparam logic [7:0] KEY_ENTER     = 8'h5A;
  localparam logic [7:0] KEY_ENTER_ALT = 8'h24;
  localparam logic [7:0] KEY_BKSP      = 8'h66;
  localparam logic [7:0] KEY_BKSP_ALT  = 8'h2D;
  localparam logic [7:0] KEY_ESC       = 8'h76;

  function automatic logic is_digit(logic [7:0] b);
    case (b)
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
      8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D: is_digit = 1'b1;
      default: is_digit = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] digit_of(logic [7:0] b);
    case (b)
      8'h16, 8'h69: digit_of = 4'd1;
      8'h1E, 8'h72: digit_of = 4'd2;
      8'h26, 8'h7A: digit_of = 4'd3;
      8'h25, 8'h6B: digit_of = 4'd4;
      8'h2E, 8'h73: digit_of = 4'd5;
      8'h36, 8'h74: digit_of = 4'd6;
      8'h3D, 8'h6C: digit_of = 4'd7;
      8'h3E, 8'h75: digit_of = 4'd8;
      8'h46, 8'h7D: digit_of = 4'd9;
      default:      digit_of = 4'd0;
    endcase
  endfunction

  function automatic logic is_enter(logic [7:0] b);
    return (b == KEY_ENTER) || (b == KEY_ENTER_ALT);
  endfunction

  function automatic logic is_bksp(logic [7:0] b);
    return (b == KEY_BKSP) || (b == KEY_BKSP_ALT);
  endfunction

  // Elaboration-time conversion of a constant into four BCD digits
  function automatic logic [15:0] bin2bcd(int v);
    int n;
    logic [15:0] r;
    n = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/numeric_entry_sevenseg.sv
// sevenseg: BCD digit to active-low segments, seg_o[0]=a .. seg_o[6]=g
module sevenseg (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Segment lookup; non-BCD codes blank the digit
  always_comb begin
    case (digit_i)
      4'd0:    seg_o = 7'h40;
      4'd1:    seg_o = 7'h79;
      4'd2:    seg_o = 7'h24;
      4'd3:    seg_o = 7'h30;
      4'd4:    seg_o = 7'h19;
      4'd5:    seg_o = 7'h12;
      4'd6:    seg_o = 7'h02;
      4'd7:    seg_o = 7'h78;
      4'd8:    seg_o = 7'h00;
      4'd9:    seg_o = 7'h10;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/numeric_entry.sv
// numeric_entry: keyboard decimal entry with clamped commit and seven-segment display
module numeric_entry
  import numeric_entry_pkg::*;
#(
  parameter int DIGITS      = 3,
  parameter int MIN_VAL     = 1,
  parameter int MAX_VAL     = 999,
  parameter int DEFAULT_VAL = 120,
  parameter int VAL_W       = 10
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  Enable,
  input  logic [7:0]            data,
  input  logic                  data_en,
  output logic [VAL_W-1:0]      value,
  output logic                  commit,
  output logic                  clamped,
  output logic [2:0]            digit_count,
  output logic                  entry_active,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int BW = 4 * DIGITS;
  localparam logic [BW-1:0] MIN_BCD = BW'(bin2bcd(MIN_VAL));
  localparam logic [BW-1:0] MAX_BCD = BW'(bin2bcd(MAX_VAL));
  localparam logic [BW-1:0] DEF_BCD = BW'(bin2bcd(DEFAULT_VAL));

  state_e           state_q, state_d;
  logic [BW-1:0]    entry_q, entry_d;
  logic [2:0]       count_q, count_d;
  logic             brk_q, brk_d, ext_q, ext_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             commit_q, commit_d, clamped_q, clamped_d;
  logic [VAL_W-1:0] bin;
  logic             lo, hi;
  logic [BW-1:0]    show;

  // Binary value of the buffered BCD digits, most significant first
  always_comb begin
    bin = '0;
    for (int i = DIGITS - 1; i >= 0; i--) bin = bin * VAL_W'(10) + VAL_W'(entry_q[4*i +: 4]);
  end

  assign lo = bin < VAL_W'(MIN_VAL);
  assign hi = bin > VAL_W'(MAX_VAL);

  // Key decoding: break/extended prefixes swallow the following code, then edit or commit
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    count_d   = count_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    value_d   = value_q;
    bcd_d     = bcd_q;
    commit_d  = 1'b0;
    clamped_d = clamped_q;
    if (!Enable) begin
      state_d = IDLE;
      entry_d = '0;
      count_d = '0;
      brk_d   = 1'b0;
      ext_d   = 1'b0;
    end else if (data_en) begin
      if (data == KEY_BREAK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (data == KEY_EXT) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        ext_d = 1'b0;
      end else if (is_digit(data)) begin
        if (count_q < 3'(DIGITS)) begin
          entry_d = (entry_q << 4) | BW'(digit_of(data));
          count_d = count_q + 3'd1;
          state_d = ENTRY;
        end
      end else if (is_bksp(data)) begin
        if (state_q == ENTRY) begin
          entry_d = entry_q >> 4;
          count_d = count_q - 3'd1;
          state_d = (count_q == 3'd1) ? IDLE : ENTRY;
        end
      end else if (is_enter(data)) begin
        if (state_q == ENTRY) begin
          value_d   = lo ? VAL_W'(MIN_VAL) : hi ? VAL_W'(MAX_VAL) : bin;
          bcd_d     = lo ? MIN_BCD : hi ? MAX_BCD : entry_q;
          clamped_d = lo | hi;
          commit_d  = 1'b1;
          entry_d   = '0;
          count_d   = '0;
          state_d   = IDLE;
        end
      end else if (data == KEY_ESC) begin
        entry_d = '0;
        count_d = '0;
        state_d = IDLE;
      end
    end
  end

  // State and committed-value registers with asynchronous reset
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      entry_q   <= '0;
      count_q   <= '0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      value_q   <= VAL_W'(DEFAULT_VAL);
      bcd_q     <= DEF_BCD;
      commit_q  <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      count_q   <= count_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      value_q   <= value_d;
      bcd_q     <= bcd_d;
      commit_q  <= commit_d;
      clamped_q <= clamped_d;
    end
  end

  assign value        = value_q;
  assign commit       = commit_q;
  assign clamped      = clamped_q;
  assign digit_count  = count_q;
  assign entry_active = state_q == ENTRY;
  assign show         = (state_q == ENTRY) ? entry_q : bcd_q;

  for (genvar i = 0; i < DIGITS; i++) begin : gen_seg
    sevenseg u_seg (.digit_i(show[4*i +: 4]), .seg_o(HEX[7*i +: 7]));
  end

endmodule

// File: tb/tb_numeric_entry.sv
// tb_numeric_entry: directed key sequences with a commit scoreboard for numeric_entry
module tb_numeric_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        data_en = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [9:0]  value;
  logic        commit, clamped, entry_active;
  logic [2:0]  digit_count;
  logic [20:0] hex;

  numeric_entry #(.DIGITS(3), .MIN_VAL(1), .MAX_VAL(300), .DEFAULT_VAL(120), .VAL_W(10)) dut (
    .Clock(clk), .nReset(rst_n), .Enable(en), .data(data), .data_en(data_en),
    .value(value), .commit(commit), .clamped(clamped), .digit_count(digit_count),
    .entry_active(entry_active), .HEX(hex)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [7:0] main_c[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic logic [6:0] seg(int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; default: return 7'h10;
    endcase
  endfunction

  function automatic logic [20:0] hex3(int a, int b, int c);
    return {seg(a), seg(b), seg(c)};
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(logic [7:0] b);
    @(negedge clk);
    data = b;
    data_en = 1'b1;
    @(negedge clk);
    data_en = 1'b0;
  endtask

  task automatic press(logic [7:0] b);
    send(b);
    send(8'hF0);
    send(b);
  endtask

  always @(negedge clk) begin
    if (commit) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got value %0d clamped %0b expected no commit", value, clamped);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({clamped, value} !== e) begin
          errors++;
          $display("FAIL commit: got value %0d clamped %0b expected value %0d clamped %0b", value, clamped, e[9:0], e[10]);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_value", value, 120);
    check("reset_hex", hex, hex3(1, 2, 0));
    check("reset_count", digit_count, 0);
    check("reset_active", entry_active, 0);
    check("reset_clamped", clamped, 0);
    repeat (5) @(negedge clk);
    press(main_c[1]); press(main_c[4]); press(main_c[0]);
    check("140_count", digit_count, 3);
    check("140_active", entry_active, 1);
    check("140_hex", hex, hex3(1, 4, 0));
    exp_q.push_back({1'b0, 10'd140});
    press(8'h5A);
    check("140_value", value, 140);
    check("140_hex_idle", hex, hex3(1, 4, 0));
    check("140_count_idle", digit_count, 0);
    repeat (4) press(main_c[9]);
    check("999_count", digit_count, 3);
    check("999_hex", hex, hex3(9, 9, 9));
    exp_q.push_back({1'b1, 10'd300});
    press(8'h24);
    check("300_value", value, 300);
    check("300_clamped", clamped, 1);
    check("300_hex", hex, hex3(3, 0, 0));
    press(main_c[0]);
    exp_q.push_back({1'b1, 10'd1});
    press(8'h5A);
    check("min_value", value, 1);
    check("min_hex", hex, hex3(0, 0, 1));
    press(main_c[5]); press(8'h66);
    check("bksp_idle", entry_active, 0);
    press(8'h66); press(8'h5A);
    check("bksp_value", value, 1);
    check("bksp_clamped", clamped, 1);
    press(main_c[7]); press(main_c[8]); press(8'h2D);
    check("bksp2_count", digit_count, 1);
    check("bksp2_hex", hex, hex3(0, 0, 7));
    press(8'h76);
    check("esc_count", digit_count, 0);
    check("esc_value", value, 1);
    press(8'h72); press(8'h73);
    exp_q.push_back({1'b0, 10'd25});
    press(8'h5A);
    check("kp_value", value, 25);
    check("kp_clamped", clamped, 0);
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
    check("ext_count", digit_count, 0);
    check("ext_active", entry_active, 0);
    send(8'hF0); send(main_c[6]);
    check("break_count", digit_count, 0);
    press(main_c[7]);
    check("after_ext_hex", hex, hex3(0, 0, 7));
    press(8'h76);
    check("esc2_active", entry_active, 0);
    check("esc2_hex", hex, hex3(0, 2, 5));
    press(main_c[2]); press(main_c[5]);
    check("en_count_before", digit_count, 2);
    en = 1'b0;
    send(main_c[7]);
    en = 1'b1;
    check("en_count", digit_count, 0);
    check("en_active", entry_active, 0);
    press(8'h5A);
    check("en_value", value, 25);
    press(main_c[3]);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", digit_count, 0);
    check("arst_value", value, 120);
    check("arst_commit", commit, 0);
    check("arst_hex", hex, hex3(1, 2, 0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("pending_commits", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/numeric_entry.md
NUMERIC_ENTRY -- requirements
Module: numeric_entry

Interface
REQ-001 SHALL have parameter DIGITS, 3, number of decimal digits accepted (legal 1..4).
REQ-002 SHALL have parameter MIN_VAL, 1, lowest committable value.
REQ-003 SHALL have parameter MAX_VAL, 999, highest committable value (MAX_VAL <= 10**DIGITS-1, MIN_VAL <= MAX_VAL).
REQ-004 SHALL have parameter DEFAULT_VAL, 120, value after reset (MIN_VAL..MAX_VAL).
REQ-005 SHALL have parameter VAL_W, 10, value width; VAL_W SHALL hold 10**DIGITS-1.
REQ-006 SHALL have ports Clock input 1 system clock, and nReset input 1 reset, asynchronous, active-low.
REQ-007 SHALL have port Enable input 1 entry enable.
REQ-008 SHALL have port data input 8 PS/2 set-2 scan byte.
REQ-009 SHALL have port data_en input 1 one-cycle strobe qualifying data.
REQ-010 SHALL have port value output VAL_W committed value.
REQ-011 SHALL have port commit output 1 one-cycle pulse on each commit.
REQ-012 SHALL have port clamped output 1 last commit was clamped to MIN_VAL or MAX_VAL.
REQ-013 SHALL have port digit_count output 3 digits currently buffered.
REQ-014 SHALL have port entry_active output 1 high in ENTRY state.
REQ-015 SHALL have port HEX output 7*DIGITS active-low segments; digit i (i=0 ones) at [7i+6:7i].

Function
REQ-016 Byte accepted only on a Clock edge with data_en=1 and Enable=1.
REQ-017 Byte 8'hF0 SHALL set break flag; next accepted byte SHALL be discarded and clear the flag.
REQ-018 Byte 8'hE0 SHALL set ext flag; next non-F0 byte SHALL be discarded and clear ext; F0 after E0 keeps ext, so E0 F0 xx discards xx and clears both flags.
REQ-019 Digit make codes: main row 45,16,1E,26,25,2E,36,3D,3E,46 and keypad 70,69,72,7A,6B,73,74,6C,75,7D map to 0..9.
REQ-020 Enter = 8'h24 and 8'h5A; Backspace = 8'h2D and 8'h66; Escape = 8'h76; all other codes ignored.
REQ-021 States: IDLE (count 0) and ENTRY (count 1..DIGITS).
REQ-022 Digit in IDLE: buffer = that digit, count=1, go ENTRY, same edge.
REQ-023 Digit in ENTRY with count<DIGITS: shift buffer left one decade, insert at ones, count+1.
REQ-024 Digit with count==DIGITS: ignored, no state change.
REQ-025 Backspace in ENTRY: shift buffer right one decade, zero top, count-1; count reaching 0 returns to IDLE.
REQ-026 Backspace or Enter in IDLE: no effect, no commit.
REQ-027 Escape: clear buffer, count=0, IDLE, value unchanged, no commit.
REQ-028 Enter in ENTRY: on the same edge, load value with the clamped binary buffer, set commit=1 for exactly the next cycle, clear buffer, and go to IDLE.
REQ-029 Binary = sum of digit_i*10**i in VAL_W bits; <MIN_VAL gives MIN_VAL, >MAX_VAL gives MAX_VAL, clamped=1; otherwise clamped=0.
REQ-030 clamped SHALL update only on commit and hold between commits.
REQ-031 Enable=0: force IDLE, clear buffer and both flags next edge; value and clamped hold; data ignored.
REQ-032 HEX SHALL show buffer in ENTRY; committed value (BCD) in IDLE; leading digits show 0.

Reset
REQ-033 nReset low SHALL asynchronously set IDLE, buffer 0, count 0, flags 0, value=DEFAULT_VAL, commit=0, clamped=0.
REQ-034 Reset mid-entry SHALL discard the buffer with no commit pulse.

Structure
REQ-035 Key-code constants, digit-decode and isDigit functions, and bin-to-BCD elaboration function SHALL live in shared package numeric_entry_pkg.
REQ-036 Committed value SHALL be kept in both binary and BCD registers; BCD of MIN_VAL/MAX_VAL computed at elaboration.
REQ-037 Existing sevenseg SHALL be the only sub-module, instantiated DIGITS times via generate.

Verification
REQ-038 Reset, no input -> value=120, HEX=1,2,0, commit never pulses.
REQ-039 Keys 1,4,0,Enter (each with F0 release) -> one commit pulse, value=140, clamped=0.
REQ-040 Keys 9,9,9,9,Enter with MAX_VAL=300 -> 4th digit ignored, value=300, clamped=1.
REQ-041 Keys 0,Enter -> value=1, clamped=1; then 5,Backspace,Backspace,Enter -> no commit.
REQ-042 E0 6B then E0 F0 6B, 7, Escape -> no digit captured, IDLE, value held.
REQ-043 Keys 2,5 then Enable=0 one cycle, then Enter -> no commit, count=0.
